gsr_ctrl: RTL and testbench
===========================

# gsr_ctrl

Global set/reset controller. It merges the asynchronous active-low system reset with an external active-low global set/reset request (GSRI). The request is synchronised and glitch-filtered, and the block drives one clean, stretched, active-low reset (O_GSRN) to all design registers, including the UART master top. It also reports reset cause and counts filtered GSRI events.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth for GSRI (≥2).
- FILTER_CYCLES, 4: consecutive low synchronised samples needed to accept a GSRI request (≥1).
- HOLD_CYCLES, 16: cycles O_GSRN stays low after all reset sources release (≥1).
- CNT_W, 8: event counter width.

Ports:
- I_CLK, in, 1: the single clock. All logic is on its rising edge.
- I_RESETN, in, 1: asynchronous active-low reset. Assertion is asynchronous; internal release is synchronous.
- GSRI, in, 1: asynchronous active-low global set/reset request. Tie to 1 when unused.
- I_CAUSE_CLR, in, 1: synchronous one-cycle pulse that clears O_CAUSE.
- O_GSRN, out, 1: registered active-low global reset output.
- O_STATE, out, 2: FSM state (0 RESET, 1 HOLD, 2 RUN).
- O_CAUSE, out, 2: sticky cause flags. Bit0 = I_RESETN occurred; bit1 = filtered GSRI occurred.
- O_EVT_CNT, out, CNT_W: saturating count of accepted GSRI assertions.

## Operation
- While I_RESETN is low, all registers are forced asynchronously to: O_GSRN=0, state RESET, O_STATE=0, O_CAUSE=2'b01, O_EVT_CNT=0, hold counter 0, filter counter 0, synchroniser flops 1 (inactive).
- GSRI passes through SYNC_STAGES flops, giving `gs`.
- Filter counter `fcnt`:
  - clears when `gs`=1;
  - increments when `gs`=0, saturating at FILTER_CYCLES.
  - `req` = (fcnt==FILTER_CYCLES). Low pulses shorter than FILTER_CYCLES synchronised cycles are ignored.
- FSM:
  - RESET: O_GSRN=0. If `req`=0, go to HOLD and set hcnt←0.
  - HOLD: O_GSRN=0. If `req`=1, go to RESET. Else if hcnt==HOLD_CYCLES-1, go to RUN and set O_GSRN←1. Else hcnt++.
  - RUN: O_GSRN=1. If `req`=1, go to RESET and set O_GSRN←0.
  - Illegal state value: go to RESET.
- O_GSRN is its own flop, loaded from the next-state decode. It is glitch-free and changes on the same edge as the state register.
- Rising edge of `req` (registered previous value):
  - O_EVT_CNT increments, holding at all-ones once saturated;
  - O_CAUSE[1] is set.
- I_CAUSE_CLR clears both O_CAUSE bits. If a set and a clear occur in the same cycle, the set wins.
- Only I_RESETN asserts O_GSRN asynchronously. A GSRI-driven assertion is synchronous.

## Timing
- I_RESETN release with GSRI high:
  - edge 1: RESET→HOLD;
  - O_GSRN rises on edge HOLD_CYCLES+1 (edge 17 with defaults).
- GSRI falls before edge 1:
  - `gs`=0 after edge SYNC_STAGES;
  - `req` asserts after edge SYNC_STAGES+FILTER_CYCLES;
  - O_GSRN falls on the next edge: edge 7 with defaults.
- GSRI rises:
  - `req` deasserts one edge after `gs` goes high (edge SYNC_STAGES+1);
  - RESET→HOLD on the following edge;
  - O_GSRN rises HOLD_CYCLES edges later.
- GSRI reasserted during HOLD: the hold count restarts from zero after the next release.
- I_RESETN asserted mid-operation: immediate asynchronous return to reset values. O_CAUSE goes to 2'b01, so bit1 history is lost by design.

## Structure
- Package `gsr_pkg`:
  - state encoding constants (ST_RESET=2'd0, ST_HOLD=2'd1, ST_RUN=2'd2);
  - default parameter values.
- Sub-module `gsr_sync`: parameterised N-flop synchroniser with async reset value 1.
- Top contains the filter, FSM, hold counter, cause and event logic.

## Test plan
- I_RESETN low for 100 cycles, GSRI=1:
  - during reset: O_GSRN=0, O_CAUSE=01, O_EVT_CNT=0;
  - after release: O_GSRN=1 exactly at edge 17; O_STATE goes 0→1→2.
- In RUN, GSRI low for 3 cycles → no change: O_GSRN=1, O_EVT_CNT=0.
- In RUN, GSRI low for 20 cycles:
  - O_GSRN=0 at edge 7 after the fall; O_EVT_CNT=1; O_CAUSE=11;
  - after GSRI rises, O_GSRN=1 at 2+1+1+16 edges.
- During HOLD, pulse GSRI low for 10 cycles → state returns to RESET; the full 16-cycle hold restarts after release.
- I_CAUSE_CLR pulse with no event → O_CAUSE=00. I_CAUSE_CLR coincident with a `req` rise → O_CAUSE[1]=1.
- CNT_W=2 with 5 accepted GSRI events → O_EVT_CNT saturates at 3. Asserting I_RESETN mid-HOLD → O_GSRN=0 asynchronously and O_EVT_CNT=0.

Source files
------------

// File: rtl/gsr_pkg.sv
// Shared state encoding and default parameter values for the global set/reset controller.
package gsr_pkg;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_HOLD  = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_FILTER_CYCLES = 4;
   localparam int DEF_HOLD_CYCLES   = 16;
   localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/gsr_sync.sv
// N-flop synchroniser for an active-low asynchronous request; resets to the inactive level (1).
module gsr_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff <= '1;
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/gsr_ctrl.sv
// Global set/reset controller: merges I_RESETN with a filtered GSRI request and drives a
// stretched, registered active-low reset, plus sticky cause flags and an event counter.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_RESET | a reset source is active, O_GSRN held low
// ST_HOLD  | sources released, counting HOLD_CYCLES before release
// ST_RUN   | O_GSRN high, normal operation
module gsr_ctrl
   import gsr_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic             I_CLK,
   input  logic             I_RESETN,
   input  logic             GSRI,
   input  logic             I_CAUSE_CLR,
   output logic             O_GSRN,
   output logic [1:0]       O_STATE,
   output logic [1:0]       O_CAUSE,
   output logic [CNT_W-1:0] O_EVT_CNT
);

   localparam int FCNT_W = $clog2(FILTER_CYCLES + 1);
   localparam int HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [FCNT_W-1:0] FCNT_MAX  = FCNT_W'(FILTER_CYCLES);
   localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLD_CYCLES - 1);

   logic              gs;
   logic [FCNT_W-1:0] fcnt;
   logic              req;
   logic              req_d;
   logic              evt_rise;

   state_t            state_q, state_d;
   logic              gsrn_q, gsrn_d;
   logic [HCNT_W-1:0] hcnt_q, hcnt_d;
   logic [1:0]        cause_q;
   logic [CNT_W-1:0]  evt_q;

   gsr_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (I_CLK),
      .rst_n (I_RESETN),
      .d     (GSRI),
      .q     (gs)
   );

   // Saturating run-length of low samples; a request is accepted only once it reaches the limit.
   always_ff @(posedge I_CLK or negedge I_RESETN) begin
      if (!I_RESETN) begin
         fcnt <= '0;
      end else if (gs) begin
         fcnt <= '0;
      end else if (fcnt != FCNT_MAX) begin
         fcnt <= fcnt + 1'b1;
      end
   end

   assign req = (fcnt == FCNT_MAX);

   always_ff @(posedge I_CLK or negedge I_RESETN) begin
      if (!I_RESETN) begin
         state_q <= ST_RESET;
         gsrn_q  <= 1'b0;
         hcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         gsrn_q  <= gsrn_d;
         hcnt_q  <= hcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gsrn_d  = gsrn_q;
      hcnt_d  = hcnt_q;
      case (state_q)
         ST_RESET: begin
            gsrn_d = 1'b0;
            if (!req) begin
               state_d = ST_HOLD;
               hcnt_d  = '0;
            end
         end
         ST_HOLD: begin
            gsrn_d = 1'b0;
            if (req) begin
               state_d = ST_RESET;
            end else if (hcnt_q == HCNT_LAST) begin
               state_d = ST_RUN;
               gsrn_d  = 1'b1;
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            gsrn_d = 1'b1;
            if (req) begin
               state_d = ST_RESET;
               gsrn_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_RESET;
            gsrn_d  = 1'b0;
         end
      endcase
   end

   assign evt_rise = req & ~req_d;

   // Cause bit1 set takes priority over a coincident clear.
   always_ff @(posedge I_CLK or negedge I_RESETN) begin
      if (!I_RESETN) begin
         req_d   <= 1'b0;
         cause_q <= 2'b01;
         evt_q   <= '0;
      end else begin
         req_d <= req;
         if (I_CAUSE_CLR) begin
            cause_q[0] <= 1'b0;
         end
         if (evt_rise) begin
            cause_q[1] <= 1'b1;
         end else if (I_CAUSE_CLR) begin
            cause_q[1] <= 1'b0;
         end
         if (evt_rise && (evt_q != '1)) begin
            evt_q <= evt_q + 1'b1;
         end
      end
   end

   assign O_GSRN    = gsrn_q;
   assign O_STATE   = state_q;
   assign O_CAUSE   = cause_q;
   assign O_EVT_CNT = evt_q;

endmodule

// File: tb/tb_gsr_ctrl.sv
// Directed bench for gsr_ctrl: default instance plus a CNT_W=2 instance sharing the same stimulus.
module tb_gsr_ctrl;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b1;
   logic       gsri     = 1'b1;
   logic       cclr     = 1'b0;
   logic       gsrn;
   logic [1:0] state;
   logic [1:0] cause;
   logic [7:0] evt;
   logic       gsrn2;
   logic [1:0] state2;
   logic [1:0] cause2;
   logic [1:0] evt2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   gsr_ctrl dut (
      .I_CLK       (clk),
      .I_RESETN    (rst_n),
      .GSRI        (gsri),
      .I_CAUSE_CLR (cclr),
      .O_GSRN      (gsrn),
      .O_STATE     (state),
      .O_CAUSE     (cause),
      .O_EVT_CNT   (evt)
   );

   gsr_ctrl #(.CNT_W(2)) dut2 (
      .I_CLK       (clk),
      .I_RESETN    (rst_n),
      .GSRI        (gsri),
      .I_CAUSE_CLR (cclr),
      .O_GSRN      (gsrn2),
      .O_STATE     (state2),
      .O_CAUSE     (cause2),
      .O_EVT_CNT   (evt2)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      tick(100);
      chk("rst_gsrn", 32'(gsrn), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_cause", 32'(cause), 32'd1);
      chk("rst_evt", 32'(evt), 32'd0);

      rst_n = 1'b1;
      tick(1);
      chk("rel_e1_state", 32'(state), 32'd1);
      tick(15);
      chk("rel_e16_gsrn", 32'(gsrn), 32'd0);
      chk("rel_e16_state", 32'(state), 32'd1);
      tick(1);
      chk("rel_e17_gsrn", 32'(gsrn), 32'd1);
      chk("rel_e17_state", 32'(state), 32'd2);
      chk("rel_cause", 32'(cause), 32'd1);

      // short glitch is filtered
      gsri = 1'b0;
      tick(3);
      gsri = 1'b1;
      tick(10);
      chk("glitch_gsrn", 32'(gsrn), 32'd1);
      chk("glitch_state", 32'(state), 32'd2);
      chk("glitch_evt", 32'(evt), 32'd0);
      chk("glitch_cause", 32'(cause), 32'd1);

      // 20-cycle request
      gsri = 1'b0;
      tick(6);
      chk("req_e6_gsrn", 32'(gsrn), 32'd1);
      tick(1);
      chk("req_e7_gsrn", 32'(gsrn), 32'd0);
      chk("req_e7_state", 32'(state), 32'd0);
      chk("req_e7_evt", 32'(evt), 32'd1);
      chk("req_e7_cause", 32'(cause), 32'd3);
      tick(13);
      gsri = 1'b1;
      tick(3);
      chk("rise_e3_state", 32'(state), 32'd0);
      tick(1);
      chk("rise_e4_state", 32'(state), 32'd1);
      tick(15);
      chk("rise_e19_gsrn", 32'(gsrn), 32'd0);
      tick(1);
      chk("rise_e20_gsrn", 32'(gsrn), 32'd1);
      chk("rise_e20_state", 32'(state), 32'd2);

      cclr = 1'b1;
      tick(1);
      cclr = 1'b0;
      chk("clr_cause", 32'(cause), 32'd0);

      // second event, then interrupt the HOLD phase with another request
      gsri = 1'b0;
      tick(20);
      gsri = 1'b1;
      tick(8);
      chk("hold_state", 32'(state), 32'd1);
      chk("hold_evt", 32'(evt), 32'd2);
      gsri = 1'b0;
      tick(7);
      chk("hold_req_state", 32'(state), 32'd0);
      chk("hold_req_evt", 32'(evt), 32'd3);
      chk("sat_evt2_3", 32'(evt2), 32'd3);
      tick(3);
      gsri = 1'b1;
      tick(4);
      chk("hold2_e4_state", 32'(state), 32'd1);
      tick(15);
      chk("hold2_e19_gsrn", 32'(gsrn), 32'd0);
      tick(1);
      chk("hold2_e20_gsrn", 32'(gsrn), 32'd1);

      // clear coincident with req rise: set wins
      cclr = 1'b1;
      tick(1);
      cclr = 1'b0;
      chk("clr2_cause", 32'(cause), 32'd0);
      gsri = 1'b0;
      tick(6);
      cclr = 1'b1;
      tick(1);
      cclr = 1'b0;
      chk("clr_set_cause", 32'(cause), 32'd2);
      chk("ev4_evt", 32'(evt), 32'd4);
      tick(10);
      gsri = 1'b1;
      tick(25);
      chk("ev4_run", 32'(state), 32'd2);

      gsri = 1'b0;
      tick(20);
      chk("ev5_evt", 32'(evt), 32'd5);
      chk("sat_evt2_5", 32'(evt2), 32'd3);

      // async reset in the middle of HOLD
      gsri = 1'b1;
      tick(5);
      chk("mid_hold_state", 32'(state), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_gsrn", 32'(gsrn), 32'd0);
      chk("async_state", 32'(state), 32'd0);
      chk("async_evt", 32'(evt), 32'd0);
      chk("async_evt2", 32'(evt2), 32'd0);
      chk("async_cause", 32'(cause), 32'd1);
      tick(3);
      rst_n = 1'b1;
      tick(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
